// File: rtl/mobilenet_v1_dw_param_loader.sv
// Fetches one depthwise channel's five-word parameter set and commits it atomically to registered outputs.
// Optional build macro MOBILENET_V1_DW_PARAM_CACHE_EN skips the refetch of the channel already committed.
module mobilenet_v1_dw_param_loader #(
    parameter int DATA_W  = 8,
    parameter int MUL_W   = 16,
    parameter int BIAS_W  = 32,
    parameter int SHIFT_W = 6,
    parameter int DIM_W   = 16,
    parameter int ADDR_W  = 20
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_req_i,
    output logic                 load_ready_o,
    input  logic [ADDR_W-1:0]    layer_base_addr_i,
    input  logic [DIM_W-1:0]     dw_ch_idx_i,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic [ADDR_W-1:0]    mem_req_addr_o,
    input  logic                 mem_rsp_valid_i,
    input  logic [31:0]          mem_rsp_data_i,
    output logic [DATA_W*9-1:0]  dw_weight_flat_o,
    output logic [MUL_W-1:0]     dw_mul_o,
    output logic [BIAS_W-1:0]    dw_bias_o,
    output logic [SHIFT_W-1:0]   dw_shift_o,
    output logic [DATA_W-1:0]    dw_relu6_max_o,
    output logic                 param_valid_o,
    output logic                 load_done_o
);
    localparam int WT_W = DATA_W * 9;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [2:0]         req_cnt_q, req_cnt_d;
    logic [2:0]         rsp_cnt_q, rsp_cnt_d;
    logic [WT_W-1:0]    sh_wt_q, sh_wt_d;
    logic [MUL_W-1:0]   sh_mul_q, sh_mul_d;
    logic [SHIFT_W-1:0] sh_shift_q, sh_shift_d;
    logic [DATA_W-1:0]  sh_relu_q, sh_relu_d;
    logic [BIAS_W-1:0]  sh_bias_q, sh_bias_d;
    logic [WT_W-1:0]    wt_q, wt_d;
    logic [MUL_W-1:0]   mul_q, mul_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0]  relu_q, relu_d;
    logic [BIAS_W-1:0]  bias_q, bias_d;
    logic               param_valid_q, param_valid_d;
    logic               load_done_q, load_done_d;
    logic [ADDR_W-1:0]  base_s;
`ifdef MOBILENET_V1_DW_PARAM_CACHE_EN
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ADDR_W-1:0]  cache_base_q, cache_base_d;
`endif

    assign base_s = layer_base_addr_i + ADDR_W'(dw_ch_idx_i) * ADDR_W'(3'd5);

    // Next-state logic: request issue, in-order response capture into the shadow, atomic commit.
    always_comb begin
        state_d       = state_q;
        req_valid_d   = req_valid_q;
        req_addr_d    = req_addr_q;
        req_cnt_d     = req_cnt_q;
        rsp_cnt_d     = rsp_cnt_q;
        sh_wt_d       = sh_wt_q;
        sh_mul_d      = sh_mul_q;
        sh_shift_d    = sh_shift_q;
        sh_relu_d     = sh_relu_q;
        sh_bias_d     = sh_bias_q;
        wt_d          = wt_q;
        mul_d         = mul_q;
        shift_d       = shift_q;
        relu_d        = relu_q;
        bias_d        = bias_q;
        param_valid_d = param_valid_q;
        load_done_d   = 1'b0;
`ifdef MOBILENET_V1_DW_PARAM_CACHE_EN
        base_d        = base_q;
        cache_base_d  = cache_base_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (load_req_i) begin
`ifdef MOBILENET_V1_DW_PARAM_CACHE_EN
                    base_d = base_s;
                    // After any commit the shadow equals the outputs, so a hit may reuse COMMIT unchanged.
                    if (param_valid_q && (base_s == cache_base_q)) begin
                        state_d = S_COMMIT;
                    end else begin
                        state_d     = S_FETCH;
                        req_valid_d = 1'b1;
                        req_addr_d  = base_s;
                        req_cnt_d   = 3'd0;
                        rsp_cnt_d   = 3'd0;
                    end
`else
                    state_d     = S_FETCH;
                    req_valid_d = 1'b1;
                    req_addr_d  = base_s;
                    req_cnt_d   = 3'd0;
                    rsp_cnt_d   = 3'd0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (req_valid_q && mem_req_ready_i) begin
                    req_addr_d  = req_addr_q + ADDR_W'(1'b1);
                    req_cnt_d   = req_cnt_q + 3'd1;
                    req_valid_d = (req_cnt_q != 3'd4);
                end else begin
                    req_addr_d = req_addr_q;
                end
                if (mem_rsp_valid_i) begin
                    case (rsp_cnt_q)
                        3'd0: sh_wt_d[31:0]  = mem_rsp_data_i;
                        3'd1: sh_wt_d[63:32] = mem_rsp_data_i;
                        3'd2: sh_wt_d[71:64] = mem_rsp_data_i[7:0];
                        3'd3: begin
                            sh_mul_d   = mem_rsp_data_i[MUL_W-1:0];
                            sh_shift_d = mem_rsp_data_i[16 +: SHIFT_W];
                            sh_relu_d  = mem_rsp_data_i[31:24];
                        end
                        3'd4: sh_bias_d = mem_rsp_data_i;
                        default: sh_bias_d = sh_bias_q;
                    endcase
                    rsp_cnt_d = rsp_cnt_q + 3'd1;
                    state_d   = (rsp_cnt_q == 3'd4) ? S_COMMIT : S_FETCH;
                end else begin
                    rsp_cnt_d = rsp_cnt_q;
                end
            end
            S_COMMIT: begin
                wt_d          = sh_wt_q;
                mul_d         = sh_mul_q;
                shift_d       = sh_shift_q;
                relu_d        = sh_relu_q;
                bias_d        = sh_bias_q;
                param_valid_d = 1'b1;
                load_done_d   = 1'b1;
                state_d       = S_IDLE;
`ifdef MOBILENET_V1_DW_PARAM_CACHE_EN
                cache_base_d  = base_q;
`endif
            end
            default: begin
                state_d     = S_IDLE;
                req_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any in-flight load and the committed set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            req_cnt_q     <= 3'd0;
            rsp_cnt_q     <= 3'd0;
            sh_wt_q       <= '0;
            sh_mul_q      <= '0;
            sh_shift_q    <= '0;
            sh_relu_q     <= '0;
            sh_bias_q     <= '0;
            wt_q          <= '0;
            mul_q         <= '0;
            shift_q       <= '0;
            relu_q        <= '0;
            bias_q        <= '0;
            param_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
`ifdef MOBILENET_V1_DW_PARAM_CACHE_EN
            base_q        <= '0;
            cache_base_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            req_cnt_q     <= req_cnt_d;
            rsp_cnt_q     <= rsp_cnt_d;
            sh_wt_q       <= sh_wt_d;
            sh_mul_q      <= sh_mul_d;
            sh_shift_q    <= sh_shift_d;
            sh_relu_q     <= sh_relu_d;
            sh_bias_q     <= sh_bias_d;
            wt_q          <= wt_d;
            mul_q         <= mul_d;
            shift_q       <= shift_d;
            relu_q        <= relu_d;
            bias_q        <= bias_d;
            param_valid_q <= param_valid_d;
            load_done_q   <= load_done_d;
`ifdef MOBILENET_V1_DW_PARAM_CACHE_EN
            base_q        <= base_d;
            cache_base_q  <= cache_base_d;
`endif
        end
    end

    assign load_ready_o     = (state_q == S_IDLE);
    assign mem_req_valid_o  = req_valid_q;
    assign mem_req_addr_o   = req_addr_q;
    assign dw_weight_flat_o = wt_q;
    assign dw_mul_o         = mul_q;
    assign dw_shift_o       = shift_q;
    assign dw_relu6_max_o   = relu_q;
    assign dw_bias_o        = bias_q;
    assign param_valid_o    = param_valid_q;
    assign load_done_o      = load_done_q;
endmodule

// File: tb/tb_mobilenet_v1_dw_param_loader.sv
// Bench for mobilenet_v1_dw_param_loader: directed loads plus randomized backpressure/latency,
// checked against a word/byte-level parameter model and a behavioural in-order memory.
module tb_mobilenet_v1_dw_param_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic        load_ready;
    logic [19:0] layer_base;
    logic [15:0] ch_idx;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [19:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [71:0] dw_weight_flat;
    logic [15:0] dw_mul;
    logic [31:0] dw_bias;
    logic [5:0]  dw_shift;
    logic [7:0]  dw_relu6_max;
    logic        param_valid;
    logic        load_done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mobilenet_v1_dw_param_loader dut (
        .clk_i(clk), .rst_i(rst), .load_req_i(load_req), .load_ready_o(load_ready),
        .layer_base_addr_i(layer_base), .dw_ch_idx_i(ch_idx),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_req_addr_o(mem_req_addr),
        .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data),
        .dw_weight_flat_o(dw_weight_flat), .dw_mul_o(dw_mul), .dw_bias_o(dw_bias),
        .dw_shift_o(dw_shift), .dw_relu6_max_o(dw_relu6_max),
        .param_valid_o(param_valid), .load_done_o(load_done)
    );

    // memory contents: explicit words, otherwise an address hash
    logic [31:0] mem [logic [19:0]];
    logic [31:0] mem_seed;
    typedef struct { logic [19:0] addr; int due; } rq_t;
    rq_t         rq[$];
    int          acc_cyc[$];
    int          last_due = 0;
    int          n_reqs, n_valid_cycles;
    logic [19:0] exp_next_addr;
    bit          rand_rdy, rand_lat;
    int          fix_lat;
    bit          stall_pend;
    logic [19:0] stall_addr;

    // expected committed set
    logic [71:0] cur_wt;
    logic [15:0] cur_mul;
    logic [5:0]  cur_shift;
    logic [7:0]  cur_relu;
    logic [31:0] cur_bias;
    logic        cur_pv;
    logic [19:0] cur_base;

    function automatic logic [31:0] mem_rd(input logic [19:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[11:0], a} ^ mem_seed;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Parameter set from the packing rules: tap n is byte n%4 of word n/4
    task automatic model(input logic [19:0] base, output logic [71:0] f, output logic [15:0] mul,
                         output logic [5:0] sh, output logic [7:0] rl, output logic [31:0] bias);
        logic [31:0] w [5];
        logic [31:0] t;
        for (int k = 0; k < 5; k++) w[k] = mem_rd(base + k[19:0]);
        f = '0;
        for (int n = 0; n < 9; n++) begin
            t = w[n / 4] >> (8 * (n % 4));
            f[8*n +: 8] = t[7:0];
        end
        t = w[3];
        mul = t[15:0];
        sh = t[21:16];
        rl = t[31:24];
        bias = w[4];
    endtask

    task automatic check_outs(input string t, input logic [71:0] wt, input logic [15:0] mul,
                              input logic [5:0] sh, input logic [7:0] rl, input logic [31:0] bias,
                              input logic pv);
        check({t, "_wt"}, dw_weight_flat, wt);
        check({t, "_mul"}, dw_mul, mul);
        check({t, "_shift"}, dw_shift, sh);
        check({t, "_relu"}, dw_relu6_max, rl);
        check({t, "_bias"}, dw_bias, bias);
        check({t, "_pv"}, param_valid, pv);
    endtask

    // Memory responder: in-order, per-request latency, optional random ready
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        stall_pend    = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                rq.delete();
                stall_pend = 1'b0;
            end
            @(negedge clk);
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_rd(rq[0].addr);
                void'(rq.pop_front());
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = $urandom;
            end
            if (stall_pend) begin
                check("stall_addr_stable", mem_req_addr, stall_addr);
                check("stall_valid_held", mem_req_valid, 1'b1);
            end
            mem_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mem_req_valid) begin
                n_valid_cycles++;
                if (mem_req_ready) begin
                    int lat, due;
                    check("req_addr", mem_req_addr, exp_next_addr);
                    exp_next_addr = exp_next_addr + 20'd1;
                    n_reqs++;
                    acc_cyc.push_back(cyc);
                    lat = rand_lat ? int'($urandom_range(1, 4)) : fix_lat;
                    due = cyc + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    rq.push_back('{addr: mem_req_addr, due: due});
                    stall_pend = 1'b0;
                end else begin
                    stall_pend = 1'b1;
                    stall_addr = mem_req_addr;
                end
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    // One load from the current negedge; returns at the negedge of the load_done cycle
    task automatic do_load(input logic [19:0] lb, input logic [15:0] ch, input int lat_exp, output int acc);
        logic [31:0] t;
        logic [19:0] base;
        logic [71:0] nw; logic [15:0] nm; logic [5:0] ns; logic [7:0] nr; logic [31:0] nb;
        bit hit, seen;
        int exp_lat;
        t = 32'(lb) + 32'(ch) * 32'd5;
        base = t[19:0];
        hit = 1'b0;
`ifdef MOBILENET_V1_DW_PARAM_CACHE_EN
        hit = cur_pv && (base == cur_base);
`endif
        exp_lat = hit ? 2 : lat_exp;
        if (hit) begin
            nw = cur_wt; nm = cur_mul; ns = cur_shift; nr = cur_relu; nb = cur_bias;
        end else begin
            model(base, nw, nm, ns, nr, nb);
        end
        check("accept_ready", load_ready, 1'b1);
        n_reqs = 0; n_valid_cycles = 0; acc_cyc.delete();
        exp_next_addr = base;
        layer_base = lb; ch_idx = ch; load_req = 1'b1;
        acc = cyc;
        @(negedge clk);
        load_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (load_done) begin
                seen = 1'b1;
                break;
            end
            check_outs("hold", cur_wt, cur_mul, cur_shift, cur_relu, cur_bias, cur_pv);
            check("busy_not_ready", load_ready, 1'b0);
            @(negedge clk);
        end
        check("load_done_seen", seen, 1'b1);
        if (exp_lat >= 0) check("done_cycle", 32'(cyc - acc), 32'(exp_lat));
        check_outs("commit", nw, nm, ns, nr, nb, 1'b1);
        check("ready_at_done", load_ready, 1'b1);
        check("req_count", 32'(n_reqs), hit ? 32'd0 : 32'd5);
        if (hit) check("hit_no_valid", 32'(n_valid_cycles), 32'd0);
        if (!hit && exp_lat >= 0 && acc_cyc.size() == 5)
            for (int k = 0; k < 5; k++) check("req_cycle", 32'(acc_cyc[k] - acc), 32'(k + 1));
        cur_wt = nw; cur_mul = nm; cur_shift = ns; cur_relu = nr; cur_bias = nb;
        cur_pv = 1'b1; cur_base = base;
    endtask

    initial begin
        int acc;
        logic [19:0] rb;
        logic [15:0] rc;
        rst = 1'b1; load_req = 1'b0; layer_base = 20'd0; ch_idx = 16'd0;
        rand_rdy = 1'b0; rand_lat = 1'b0; fix_lat = 1;
        mem_seed = $urandom;
        cur_wt = '0; cur_mul = '0; cur_shift = '0; cur_relu = '0; cur_bias = '0;
        cur_pv = 1'b0; cur_base = '0;
        n_valid_cycles = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_outs("reset", 72'd0, 16'd0, 6'd0, 8'd0, 32'd0, 1'b0);
        check("reset_done", load_done, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_valid", mem_req_valid, 1'b0);
            check("idle_ready", load_ready, 1'b1);
        end
        check("idle_valid_cycles", 32'(n_valid_cycles), 32'd0);

        // directed set at 0x100 + 2*5
        mem[20'h10A] = 32'h03020100;
        mem[20'h10B] = 32'h07060504;
        mem[20'h10C] = 32'hFFFFFF08;
        mem[20'h10D] = 32'h7F151234;
        mem[20'h10E] = 32'h00000400;
        do_load(20'h100, 16'd2, 8, acc);
        check_outs("directed", 72'h080706050403020100, 16'h1234, 6'h15, 8'h7F, 32'h400, 1'b1);

        // second load while valid, fixed latency 2, accepted on the load_done cycle
        fix_lat = 2;
        do_load(20'h100, 16'd7, 9, acc);

        // backpressure and random latency
        rand_rdy = 1'b1; rand_lat = 1'b1;
        do_load(20'h3000, 16'd5, -1, acc);
        do_load(20'h100, 16'd2, -1, acc);
        check_outs("random_directed", 72'h080706050403020100, 16'h1234, 6'h15, 8'h7F, 32'h400, 1'b1);
        do_load(20'hFFFFE, 16'd0, -1, acc);
        for (int i = 0; i < 8; i++) begin
            rb = 20'($urandom);
            rc = 16'($urandom);
            do_load(rb, rc, -1, acc);
        end

        // reset during the 3rd response (L=1, ready=1)
        rand_rdy = 1'b0; rand_lat = 1'b0; fix_lat = 1;
        @(negedge clk);
        exp_next_addr = 20'h200 + 20'd45;
        layer_base = 20'h200; ch_idx = 16'd9; load_req = 1'b1;
        acc = cyc;
        @(negedge clk);
        load_req = 1'b0;
        repeat (3) @(negedge clk);
        check("third_rsp_cycle", mem_rsp_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cur_wt = '0; cur_mul = '0; cur_shift = '0; cur_relu = '0; cur_bias = '0; cur_pv = 1'b0;
        check_outs("abort", cur_wt, cur_mul, cur_shift, cur_relu, cur_bias, cur_pv);
        check("abort_ready", load_ready, 1'b1);
        check("abort_valid", mem_req_valid, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", load_done, 1'b0);
            check("abort_pv", param_valid, 1'b0);
        end
        do_load(20'h200, 16'd9, 8, acc);

        // same channel again (cache hit when enabled), then a different channel
        do_load(20'h200, 16'd9, 8, acc);
        do_load(20'h200, 16'd10, 8, acc);
        @(negedge clk);
        check("done_pulse_width", load_done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mobilenet_v1_dw_param_loader.md
# mobilenet_v1_dw_param_loader

Fetches one depthwise channel's parameter set from the parameter memory and holds it on registered outputs for the depthwise conv engine. It is the upstream replacement for the constant-zero depthwise outputs of the parameter stub. It assembles five 32-bit memory words into the 9-tap weight vector, requant multiplier, bias, shift and ReLU6 clamp. It then commits all fields atomically, so the engine keeps using the current set while the next channel prefetches.

## Interface
- DATA_W, 8, weight/clamp width; fixed at 8 by the packing format
- MUL_W, 16, requant multiplier width; at most 16
- BIAS_W, 32, requant bias width; fixed at 32
- SHIFT_W, 6, shift width; at most 6
- DIM_W, 16, index width
- ADDR_W, 20, parameter memory word-address width
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- load_req  in  1  request to load a channel
- load_ready  out  1  high only in IDLE
- layer_base_addr  in  ADDR_W  word address of the layer's depthwise block; sampled on accept
- dw_ch_idx  in  DIM_W  channel to load; sampled on accept
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  ADDR_W  word address
- mem_rsp_valid  in  1  read data valid; responses return in order, any latency of at least 1 cycle
- mem_rsp_data  in  32  read data
- dw_weight_flat  out  DATA_W*9  tap k at bits [8k+:8]
- dw_mul  out  MUL_W  requant multiplier
- dw_bias  out  BIAS_W  requant bias
- dw_shift  out  SHIFT_W  requant shift
- dw_relu6_max  out  DATA_W  ReLU6 clamp
- param_valid  out  1  outputs hold a committed set
- load_done  out  1  one-cycle pulse on commit

## Operation
- The set starts at word address base = layer_base_addr + dw_ch_idx*5 and spans words base+0 to base+4. Address arithmetic is modulo 2^ADDR_W.
- Word 0 holds taps 0–3, word 1 holds taps 4–7, and word 2 byte 0 holds tap 8. Packing is little-endian, so tap n is in byte n%4. Word 2 bytes 1–3 are ignored.
- Word 3 layout: [15:0] is mul and [21:16] is shift; MUL_W/SHIFT_W narrower than the field take the low bits. [31:24] is relu6_max. [23:22] are ignored.
- Word 4 is bias.
- The FSM has three states: IDLE, FETCH, COMMIT.
  - IDLE: load_ready=1. On load_req, latch the base address and go to FETCH.
  - FETCH: issue requests for word indices 0..4 in order. A request advances the index only on mem_req_valid&&mem_req_ready. mem_req_valid drops after word 4 is accepted.
  - FETCH, responses: each mem_rsp_valid writes the next shadow field, using an independent response counter 0..4. Responses may arrive while later requests are still pending.
  - FETCH exit: when the 5th response is captured, go to COMMIT.
  - COMMIT: copy all shadow fields to the outputs in one edge, set param_valid=1, pulse load_done, and return to IDLE.
- The outputs never change except at COMMIT or reset. param_valid stays 1 through later fetches.
- mem_rsp_valid in IDLE or COMMIT is ignored.
- The memory side shares rst, so no stale responses survive a reset.

## Timing
- Reset values: all parameter outputs 0, param_valid 0, load_done 0, mem_req_valid 0, load_ready 1 (IDLE).
- Reset mid-FETCH or mid-COMMIT aborts the load. The shadow is discarded and no commit happens.
- Define the accept edge as cycle 0. mem_req_valid is first high in cycle 1.
- With mem_req_ready=1 and response latency L, requests occupy cycles 1–5.
- The last response arrives in cycle 5+L. COMMIT is cycle 6+L, and the new outputs and load_done are visible from cycle 7+L.
- load_ready is low from cycle 1 until back in IDLE. The earliest next accept is the cycle load_done is high.
- Stalled mem_req_ready holds mem_req_addr stable.

## Configuration
- MOBILENET_V1_DW_PARAM_CACHE_EN defined: the block remembers the base address of the committed set.
  - A load_req whose computed base equals the remembered base while param_valid=1 skips FETCH and goes straight to COMMIT.
  - The outputs are unchanged, load_done pulses in cycle 2, and no memory requests are issued.
  - Reset clears the remembered base's validity.
- Macro undefined: every load fetches from memory.

## Test plan
- Reset then idle: all outputs 0, param_valid=0, load_ready=1, and no mem_req_valid for 20 cycles.
- Load base=0x100, ch=2 with memory at L=1 and ready=1:
  - addresses 0x10A–0x10E in cycles 1–5;
  - memory words 0x03020100, 0x07060504, 0xFFFFFF08, 0x7F151234, 0x00000400;
  - required: taps 0..8 = 0x00..0x08, mul=0x1234, shift=0x15, relu6_max=0x7F, bias=0x400;
  - load_done in cycle 8.
- Random mem_req_ready backpressure and response latency 1–4: addresses stay stable while stalled, the same final values as the previous scenario are produced, and the outputs hold the old set until commit.
- Second load while the first set is valid: param_valid stays 1, and dw_* holds the first values until the new load_done.
- Assert rst during the 3rd response: outputs return to 0 and param_valid=0. A fresh load afterwards completes correctly.
- With MOBILENET_V1_DW_PARAM_CACHE_EN: repeat the same channel load → no mem_req_valid, load_done in cycle 2. A different channel → full fetch.
